grey_counter: RTL and testbench
===============================

// Module: grey_counter
// PURPOSE
//  Up/down pointer counter that holds its state in binary and publishes a registered Grey-coded value.
//  Sits directly upstream of the Grey decoder; typical client is a FIFO pointer or position tracker.
//  Every increment/decrement changes exactly one bit of enc_o, so enc_o is safe to sample in another domain.
//  The consumer decodes enc_o back to binary.
// PARAMETERS
//  WIDTH  2  counter/code width; supported 2..4 (matches decoder); any other value instantiates PanicModule
//  WRAP   1  1: wrap modulo 2**WIDTH; 0: saturate at 0 and 2**WIDTH-1
// PORTS
//  clk_i       in   1      single clock, all state on rising edge
//  reset_i     in   1      synchronous, active-high reset
//  inc_i       in   1      count up by one this cycle
//  dec_i       in   1      count down by one this cycle
//  load_i      in   1      load load_val_i (binary) this cycle
//  load_val_i  in   WIDTH  binary value to load
//  enc_o       out  WIDTH  registered Grey code of current count
//  raw_o       out  WIDTH  registered binary count
//  wrap_o      out  1      one-cycle pulse: the last update wrapped (max->0 or 0->max)
//  at_max_o    out  1      raw_o == 2**WIDTH-1
//  at_min_o    out  1      raw_o == 0
// BEHAVIOUR
//  - Reset (sync, active-high): raw_o=0, enc_o=0, wrap_o=0, at_min_o=1, at_max_o=0. Reset wins over all inputs.
//    Reset asserted mid-count clears the count on the next edge; no partial update is kept.
//  - Priority per cycle: reset > load > (inc XOR dec) > hold.
//  - load_i=1: raw_o <= load_val_i and enc_o <= bin2grey(load_val_i). wrap_o <= 0. inc_i/dec_i are ignored.
//    A load may change several enc_o bits; this is the only case allowed to.
//  - inc_i & dec_i both 1 (no load): hold, wrap_o <= 0.
//  - inc only: next = raw+1.
//    At max: WRAP=1 -> next=0, wrap_o<=1. WRAP=0 -> hold at max, wrap_o<=0.
//  - dec only: next = raw-1.
//    At 0: WRAP=1 -> next=max, wrap_o<=1. WRAP=0 -> hold at 0, wrap_o<=0.
//  - Latency: an input in cycle N is visible on enc_o/raw_o/flags after edge N+1. Outputs are registered, no comb path in->out.
//  - enc_o = raw_o ^ (raw_o >> 1), always consistent with raw_o in the same cycle.
//    Both come from one registered binary value plus a registered encode of next-state. They never diverge by one cycle.
//  - Arithmetic: WIDTH bits, unsigned; overflow handled only by the wrap/saturate rule above.
//  - at_max_o/at_min_o are derived from the registered raw_o. They are valid every cycle, including right after reset and load.
//  - Invariant (non-load updates): popcount(enc_o_prev ^ enc_o) <= 1.
// STRUCTURE
//  - Package grey_pkg: function bin2grey(logic[3:0]), localparams GREY_MIN_WIDTH=2 and GREY_MAX_WIDTH=4.
//    The decoder may later reuse the package.
//  - One natural sub-module: grey_encode, combinational, WIDTH-param, binary in -> Grey out.
//    Applied to next-state before the register.
//  - Top: next-state logic + registers + flag logic.
//  - Width guard: a generate block instantiates PanicModule outside 2..4.
// TESTING
//  1) WIDTH=3: reset then 5x inc -> raw_o=3'b101, enc_o=3'b111, at_min_o=0; each step changes exactly 1 enc bit.
//  2) WIDTH=3 WRAP=1: load 7, then inc -> raw_o=0, enc_o=000, wrap_o=1 for exactly one cycle.
//     Then dec -> raw_o=7, enc_o=100, wrap_o=1.
//  3) WIDTH=3 WRAP=0: load 7, inc -> raw_o=7, wrap_o=0, at_max_o=1. Load 0, dec -> raw_o=0, at_min_o=1.
//  4) WIDTH=4: inc=dec=1 for 3 cycles from raw=9 -> raw_o stays 9, enc_o=4'b1101.
//     load_i=1 with inc_i=1, load_val=12 -> raw_o=12, enc_o=4'b1010.
//  5) WIDTH=2: count to 2 (enc 11), assert reset_i with inc_i=1 -> next cycle raw_o=0, enc_o=00, wrap_o=0.
//  6) Sweep all WIDTH in 2..4: feed enc_o to the Grey decoder and check decoded == raw_o every cycle over 3 full wraps.

Source files
------------

// File: rtl/grey_pkg.sv
// rtl/grey_pkg.sv - Shared Grey-code width limits and binary-to-Grey helper
package grey_pkg;

  localparam int GREY_MIN_WIDTH = 2;
  localparam int GREY_MAX_WIDTH = 4;

  function automatic logic [GREY_MAX_WIDTH-1:0] bin2grey(input logic [GREY_MAX_WIDTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/grey_encode.sv
// rtl/grey_encode.sv - Combinational binary-to-Grey encoder, WIDTH bits
module grey_encode
  import grey_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] grey_o
);

  // Zero-extend into the shared helper; the padded high bits encode to zero.
  assign grey_o = WIDTH'(bin2grey(GREY_MAX_WIDTH'(bin_i)));

endmodule

// File: rtl/panic_module.sv
// rtl/panic_module.sv - Empty marker module; its presence in a netlist flags an unsupported configuration
module PanicModule;
endmodule

// File: rtl/grey_counter.sv
// rtl/grey_counter.sv - Up/down binary counter publishing a registered Grey code
// Grey code is computed from next-state so enc_o and raw_o update on the same edge.
module grey_counter
  import grey_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter bit WRAP  = 1'b1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] enc_o,
  output logic [WIDTH-1:0] raw_o,
  output logic             wrap_o,
  output logic             at_max_o,
  output logic             at_min_o
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;
  localparam logic [WIDTH-1:0] MIN_VAL = '0;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  if (WIDTH < GREY_MIN_WIDTH || WIDTH > GREY_MAX_WIDTH) begin : g_width_guard
    PanicModule u_panic ();
  end

  logic [WIDTH-1:0] raw_d, raw_q;
  logic [WIDTH-1:0] enc_d, enc_q;
  logic             wrap_d, wrap_q;

  logic up, down;
  assign up   = inc_i & ~dec_i;
  assign down = dec_i & ~inc_i;

  always_comb begin
    raw_d  = raw_q;
    wrap_d = 1'b0;
    if (load_i) begin
      raw_d = load_val_i;
    end else if (up) begin
      if (raw_q == MAX_VAL) begin
        if (WRAP) begin
          raw_d  = MIN_VAL;
          wrap_d = 1'b1;
        end
      end else begin
        raw_d = raw_q + ONE;
      end
    end else if (down) begin
      if (raw_q == MIN_VAL) begin
        if (WRAP) begin
          raw_d  = MAX_VAL;
          wrap_d = 1'b1;
        end
      end else begin
        raw_d = raw_q - ONE;
      end
    end
  end

  grey_encode #(
    .WIDTH (WIDTH)
  ) u_encode (
    .bin_i  (raw_d),
    .grey_o (enc_d)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      raw_q  <= '0;
      enc_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      raw_q  <= raw_d;
      enc_q  <= enc_d;
      wrap_q <= wrap_d;
    end
  end

  assign raw_o    = raw_q;
  assign enc_o    = enc_q;
  assign wrap_o   = wrap_q;
  assign at_max_o = (raw_q == MAX_VAL);
  assign at_min_o = (raw_q == MIN_VAL);

endmodule

// File: tb/tb_grey_counter.sv
// tb/tb_grey_counter.sv - Directed self-checking bench for grey_counter
module tb_grey_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // WIDTH=2 WRAP=1
  logic rst2 = 1'b0, inc2 = 1'b0, dec2 = 1'b0, ld2 = 1'b0;
  logic [1:0] lv2 = '0, enc2, raw2;
  logic wrap2, max2, min2;
  // WIDTH=3 WRAP=1
  logic rst3w = 1'b0, inc3w = 1'b0, dec3w = 1'b0, ld3w = 1'b0;
  logic [2:0] lv3w = '0, enc3w, raw3w;
  logic wrap3w, max3w, min3w;
  // WIDTH=3 WRAP=0
  logic rst3s = 1'b0, inc3s = 1'b0, dec3s = 1'b0, ld3s = 1'b0;
  logic [2:0] lv3s = '0, enc3s, raw3s;
  logic wrap3s, max3s, min3s;
  // WIDTH=4 WRAP=1
  logic rst4 = 1'b0, inc4 = 1'b0, dec4 = 1'b0, ld4 = 1'b0;
  logic [3:0] lv4 = '0, enc4, raw4;
  logic wrap4, max4, min4;

  grey_counter #(.WIDTH(2), .WRAP(1'b1)) u_w2 (
    .clk_i(clk), .reset_i(rst2), .inc_i(inc2), .dec_i(dec2), .load_i(ld2), .load_val_i(lv2),
    .enc_o(enc2), .raw_o(raw2), .wrap_o(wrap2), .at_max_o(max2), .at_min_o(min2));

  grey_counter #(.WIDTH(3), .WRAP(1'b1)) u_w3_wrap (
    .clk_i(clk), .reset_i(rst3w), .inc_i(inc3w), .dec_i(dec3w), .load_i(ld3w), .load_val_i(lv3w),
    .enc_o(enc3w), .raw_o(raw3w), .wrap_o(wrap3w), .at_max_o(max3w), .at_min_o(min3w));

  grey_counter #(.WIDTH(3), .WRAP(1'b0)) u_w3_sat (
    .clk_i(clk), .reset_i(rst3s), .inc_i(inc3s), .dec_i(dec3s), .load_i(ld3s), .load_val_i(lv3s),
    .enc_o(enc3s), .raw_o(raw3s), .wrap_o(wrap3s), .at_max_o(max3s), .at_min_o(min3s));

  grey_counter #(.WIDTH(4), .WRAP(1'b1)) u_w4 (
    .clk_i(clk), .reset_i(rst4), .inc_i(inc4), .dec_i(dec4), .load_i(ld4), .load_val_i(lv4),
    .enc_o(enc4), .raw_o(raw4), .wrap_o(wrap4), .at_max_o(max4), .at_min_o(min4));

  function automatic logic [3:0] grey_dec(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst2 = 1'b1; rst3w = 1'b1; rst3s = 1'b1; rst4 = 1'b1;
    inc3w = 1'b1;
    tick();
    tick();
    inc3w = 1'b0;
    checks++; if (raw3w !== 3'd0) begin errors++; $display("FAIL reset_raw got %b exp %b", raw3w, 3'd0); end
    checks++; if (enc3w !== 3'd0) begin errors++; $display("FAIL reset_enc got %b exp %b", enc3w, 3'd0); end
    checks++; if (wrap3w !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b exp 0", wrap3w); end
    checks++; if (min3w !== 1'b1) begin errors++; $display("FAIL reset_at_min got %b exp 1", min3w); end
    checks++; if (max3w !== 1'b0) begin errors++; $display("FAIL reset_at_max got %b exp 0", max3w); end
    checks++; if (raw4 !== 4'd0 || enc4 !== 4'd0) begin errors++; $display("FAIL reset_w4 got raw %b enc %b exp 0000", raw4, enc4); end
    checks++; if (raw2 !== 2'd0 || min2 !== 1'b1) begin errors++; $display("FAIL reset_w2 got raw %b min %b exp 00/1", raw2, min2); end
    rst2 = 1'b0; rst3w = 1'b0; rst3s = 1'b0; rst4 = 1'b0;
  endtask

  task automatic test_count_up();
    logic [2:0] exp_enc [5];
    logic [2:0] prev;
    exp_enc = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111};
    prev = enc3w;
    inc3w = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++; if (raw3w !== 3'(k)) begin errors++; $display("FAIL count_raw step %0d got %b exp %b", k, raw3w, 3'(k)); end
      checks++; if (enc3w !== exp_enc[k-1]) begin errors++; $display("FAIL count_enc step %0d got %b exp %b", k, enc3w, exp_enc[k-1]); end
      checks++; if ($countones(prev ^ enc3w) != 1) begin errors++; $display("FAIL count_one_bit step %0d got %b->%b exp 1 bit change", k, prev, enc3w); end
      prev = enc3w;
    end
    inc3w = 1'b0;
    checks++; if (min3w !== 1'b0) begin errors++; $display("FAIL count_at_min got %b exp 0", min3w); end
  endtask

  task automatic test_wrap();
    ld3w = 1'b1; lv3w = 3'd7;
    tick();
    ld3w = 1'b0;
    checks++; if (raw3w !== 3'd7 || enc3w !== 3'b100) begin errors++; $display("FAIL wrap_load got raw %b enc %b exp 111/100", raw3w, enc3w); end
    checks++; if (max3w !== 1'b1) begin errors++; $display("FAIL wrap_load_at_max got %b exp 1", max3w); end
    inc3w = 1'b1;
    tick();
    inc3w = 1'b0;
    checks++; if (raw3w !== 3'd0 || enc3w !== 3'b000) begin errors++; $display("FAIL wrap_inc got raw %b enc %b exp 000/000", raw3w, enc3w); end
    checks++; if (wrap3w !== 1'b1) begin errors++; $display("FAIL wrap_inc_pulse got %b exp 1", wrap3w); end
    tick();
    checks++; if (wrap3w !== 1'b0 || raw3w !== 3'd0) begin errors++; $display("FAIL wrap_pulse_end got wrap %b raw %b exp 0/000", wrap3w, raw3w); end
    dec3w = 1'b1;
    tick();
    dec3w = 1'b0;
    checks++; if (raw3w !== 3'd7 || enc3w !== 3'b100) begin errors++; $display("FAIL wrap_dec got raw %b enc %b exp 111/100", raw3w, enc3w); end
    checks++; if (wrap3w !== 1'b1) begin errors++; $display("FAIL wrap_dec_pulse got %b exp 1", wrap3w); end
    tick();
    checks++; if (wrap3w !== 1'b0) begin errors++; $display("FAIL wrap_dec_pulse_end got %b exp 0", wrap3w); end
  endtask

  task automatic test_saturate();
    ld3s = 1'b1; lv3s = 3'd7;
    tick();
    ld3s = 1'b0;
    checks++; if (max3s !== 1'b1) begin errors++; $display("FAIL sat_load_at_max got %b exp 1", max3s); end
    inc3s = 1'b1;
    tick();
    inc3s = 1'b0;
    checks++; if (raw3s !== 3'd7 || enc3s !== 3'b100) begin errors++; $display("FAIL sat_hi got raw %b enc %b exp 111/100", raw3s, enc3s); end
    checks++; if (wrap3s !== 1'b0 || max3s !== 1'b1) begin errors++; $display("FAIL sat_hi_flags got wrap %b max %b exp 0/1", wrap3s, max3s); end
    ld3s = 1'b1; lv3s = 3'd0;
    tick();
    ld3s = 1'b0;
    dec3s = 1'b1;
    tick();
    dec3s = 1'b0;
    checks++; if (raw3s !== 3'd0 || enc3s !== 3'b000) begin errors++; $display("FAIL sat_lo got raw %b enc %b exp 000/000", raw3s, enc3s); end
    checks++; if (wrap3s !== 1'b0 || min3s !== 1'b1) begin errors++; $display("FAIL sat_lo_flags got wrap %b min %b exp 0/1", wrap3s, min3s); end
  endtask

  task automatic test_hold_and_load();
    ld4 = 1'b1; lv4 = 4'd9;
    tick();
    ld4 = 1'b0;
    checks++; if (raw4 !== 4'd9 || enc4 !== 4'b1101) begin errors++; $display("FAIL hold_load9 got raw %b enc %b exp 1001/1101", raw4, enc4); end
    inc4 = 1'b1; dec4 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (raw4 !== 4'd9 || enc4 !== 4'b1101 || wrap4 !== 1'b0) begin
        errors++; $display("FAIL hold_both cycle %0d got raw %b enc %b wrap %b exp 1001/1101/0", k, raw4, enc4, wrap4);
      end
    end
    dec4 = 1'b0;
    ld4 = 1'b1; lv4 = 4'd12;
    tick();
    ld4 = 1'b0; inc4 = 1'b0;
    checks++; if (raw4 !== 4'd12 || enc4 !== 4'b1010) begin errors++; $display("FAIL load_over_inc got raw %b enc %b exp 1100/1010", raw4, enc4); end
    checks++; if (wrap4 !== 1'b0) begin errors++; $display("FAIL load_wrap got %b exp 0", wrap4); end
  endtask

  task automatic test_reset_midcount();
    inc2 = 1'b1;
    tick();
    tick();
    checks++; if (raw2 !== 2'd2 || enc2 !== 2'b11) begin errors++; $display("FAIL mid_count got raw %b enc %b exp 10/11", raw2, enc2); end
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0;
    checks++; if (raw2 !== 2'd0 || enc2 !== 2'b00 || wrap2 !== 1'b0) begin
      errors++; $display("FAIL mid_reset got raw %b enc %b wrap %b exp 00/00/0", raw2, enc2, wrap2);
    end
    tick();
    tick();
    tick();
    checks++; if (raw2 !== 2'd3 || enc2 !== 2'b10 || max2 !== 1'b1) begin
      errors++; $display("FAIL mid_to_max got raw %b enc %b max %b exp 11/10/1", raw2, enc2, max2);
    end
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0; inc2 = 1'b0;
    checks++; if (raw2 !== 2'd0 || wrap2 !== 1'b0 || min2 !== 1'b1) begin
      errors++; $display("FAIL reset_beats_wrap got raw %b wrap %b min %b exp 00/0/1", raw2, wrap2, min2);
    end
  endtask

  task automatic test_sweep();
    int e2, e3, e4;
    logic [3:0] p2, p3, p4;
    rst2 = 1'b1; rst3w = 1'b1; rst4 = 1'b1;
    tick();
    rst2 = 1'b0; rst3w = 1'b0; rst4 = 1'b0;
    e2 = 0; e3 = 0; e4 = 0;
    p2 = {2'b00, enc2}; p3 = {1'b0, enc3w}; p4 = enc4;
    inc2 = 1'b1; inc3w = 1'b1; inc4 = 1'b1;
    for (int c = 0; c < 48; c++) begin
      tick();
      e2 = (e2 + 1) % 4; e3 = (e3 + 1) % 8; e4 = (e4 + 1) % 16;
      checks++; if (grey_dec({2'b00, enc2}) !== {2'b00, raw2} || raw2 !== 2'(e2) || wrap2 !== (e2 == 0)) begin
        errors++; $display("FAIL sweep_w2 cyc %0d got raw %b enc %b wrap %b exp raw %0d", c, raw2, enc2, wrap2, e2);
      end
      checks++; if (grey_dec({1'b0, enc3w}) !== {1'b0, raw3w} || raw3w !== 3'(e3) || wrap3w !== (e3 == 0)) begin
        errors++; $display("FAIL sweep_w3 cyc %0d got raw %b enc %b wrap %b exp raw %0d", c, raw3w, enc3w, wrap3w, e3);
      end
      checks++; if (grey_dec(enc4) !== raw4 || raw4 !== 4'(e4) || wrap4 !== (e4 == 0)) begin
        errors++; $display("FAIL sweep_w4 cyc %0d got raw %b enc %b wrap %b exp raw %0d", c, raw4, enc4, wrap4, e4);
      end
      checks++; if ($countones(p2 ^ {2'b00, enc2}) != 1 || $countones(p3 ^ {1'b0, enc3w}) != 1 || $countones(p4 ^ enc4) != 1) begin
        errors++; $display("FAIL sweep_one_bit cyc %0d got %b %b %b exp single-bit steps", c, enc2, enc3w, enc4);
      end
      p2 = {2'b00, enc2}; p3 = {1'b0, enc3w}; p4 = enc4;
    end
    inc2 = 1'b0; inc3w = 1'b0; inc4 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_count_up();
    test_wrap();
    test_saturate();
    test_hold_and_load();
    test_reset_midcount();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
